// File: rtl/mux_scan_ctrl.sv
// Scans a 4:1 mux through the enabled channels and returns the captured bits as one word; SCAN_CONTINUOUS_EN lets start in DONE chain passes.
// Pass takes n*DWELL SETTLE cycles plus one DONE cycle; start is the only request and is ignored while busy.
module mux_scan_ctrl #(
    parameter int DWELL = 2
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       start_i,
    input  logic [3:0] ch_mask_i,
    input  logic       mux_dout_i,
    output logic [1:0] sel_o,
    output logic       busy_o,
    output logic       done_o,
    output logic [3:0] sample_o
);
    localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [DW-1:0] DCNT_LAST = DW'(DWELL - 1);

    typedef enum logic [1:0] {IDLE, SETTLE, DONE} state_t;

    state_t          state_q, state_d;
    logic [3:0]      mask_q, mask_d;
    logic [1:0]      ch_q, ch_d;
    logic [DW-1:0]   dcnt_q, dcnt_d;
    logic [3:0]      shadow_q, shadow_d;
    logic [1:0]      sel_q, sel_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [3:0]      sample_q, sample_d;
    logic            launch;
    logic [2:0]      nxt;

    function automatic logic [1:0] first_ch(input logic [3:0] m);
        logic [1:0] r;
        r = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (m[i]) r = 2'(i);
        end
        return r;
    endfunction

    // Returns {found, channel} for the lowest enabled channel above c.
    function automatic logic [2:0] next_ch(input logic [3:0] m, input logic [1:0] c);
        logic [2:0] r;
        r = 3'd0;
        for (int i = 3; i >= 0; i--) begin
            if (m[i] && (i > int'(c))) r = {1'b1, 2'(i)};
        end
        return r;
    endfunction

`ifdef SCAN_CONTINUOUS_EN
    assign launch = start_i && ((state_q == IDLE) || (state_q == DONE));
`else
    assign launch = start_i && (state_q == IDLE);
`endif

    assign nxt = next_ch(mask_q, ch_q);

    always_comb begin
        state_d  = state_q;
        mask_d   = mask_q;
        ch_d     = ch_q;
        dcnt_d   = dcnt_q;
        shadow_d = shadow_q;
        sample_d = sample_q;

        case (state_q)
            SETTLE: begin
                if (dcnt_q == DCNT_LAST) begin
                    shadow_d[ch_q] = mux_dout_i;
                    dcnt_d         = '0;
                    if (nxt[2]) begin
                        ch_d = nxt[1:0];
                    end else begin
                        state_d = DONE;
                    end
                end else begin
                    dcnt_d = dcnt_q + 1'b1;
                end
            end
            DONE: begin
                sample_d = shadow_q;
                state_d  = IDLE;
            end
            default: ;
        endcase

        if (launch) begin
            shadow_d = '0;
            if (ch_mask_i != 4'b0000) begin
                mask_d  = ch_mask_i;
                ch_d    = first_ch(ch_mask_i);
                dcnt_d  = '0;
                state_d = SETTLE;
            end else begin
                state_d = DONE;
            end
        end

        // Outputs are registered images of the state being entered.
        busy_d = (state_d == SETTLE);
        done_d = (state_d == DONE);
        sel_d  = (state_d == SETTLE) ? ch_d : 2'd0;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            mask_q   <= '0;
            ch_q     <= '0;
            dcnt_q   <= '0;
            shadow_q <= '0;
            sel_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            sample_q <= '0;
        end else begin
            state_q  <= state_d;
            mask_q   <= mask_d;
            ch_q     <= ch_d;
            dcnt_q   <= dcnt_d;
            shadow_q <= shadow_d;
            sel_q    <= sel_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            sample_q <= sample_d;
        end
    end

    assign sel_o    = sel_q;
    assign busy_o   = busy_q;
    assign done_o   = done_q;
    assign sample_o = sample_q;
endmodule
